// File: rtl/bcd_accumulator_display.sv
// Digit-serial BCD accumulator (load/add/subtract/clear, LSD first) with one
// active-low seven-segment pattern per accumulator digit.
module bcd_accumulator_display #(
   parameter int DIGITS = 4,
   parameter bit BLANK  = 1'b1
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [4*DIGITS-1:0]   operand,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  invalid,
   output logic [4*DIGITS-1:0]   acc,
   output logic [7*DIGITS-1:0]   hex,
   output logic [1:0]            dbg_state
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef enum logic [1:0] {IDLE, CHECK, ADD, DONE} state_t;

   state_t               state_q, state_d;
   logic [1:0]           op_q;
   logic [4*DIGITS-1:0]  operand_q;
   logic [4*DIGITS-1:0]  work_q, work_d;
   logic [IDX_W-1:0]     idx_q;
   logic                 carry_q;
   logic                 bad_digit;
   logic                 last_digit;
   logic [3:0]           a_dig, b_raw, b_dig, res_dig;
   logic [4:0]           sum;
   logic                 carry_out;

   // Handshake: a request is accepted on any rising edge where start=1 and
   // busy=0; done pulses once when the result is on acc, busy drops a cycle later.
   assign dbg_state = state_q;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (operand_q[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // One digit slice of the serial adder; subtract adds the nines' complement.
   always_comb begin
      a_dig      = acc[4*idx_q +: 4];
      b_raw      = operand_q[4*idx_q +: 4];
      b_dig      = (op_q == OP_SUB) ? (4'd9 - b_raw) : b_raw;
      sum        = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
      carry_out  = (sum > 5'd9);
      res_dig    = carry_out ? 4'(sum - 5'd10) : sum[3:0];
      work_d     = work_q;
      work_d[4*idx_q +: 4] = res_dig;
      last_digit = (idx_q == IDX_W'(DIGITS - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = CHECK;
         CHECK: state_d = ((op_q == OP_ADD || op_q == OP_SUB) && !bad_digit) ? ADD : DONE;
         ADD:   if (last_digit) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         invalid   <= 1'b0;
         acc       <= '0;
         work_q    <= '0;
         op_q      <= OP_LOAD;
         operand_q <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
      end else begin
         busy <= (state_d != IDLE);
         done <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q      <= op;
                  operand_q <= operand;
               end
            end
            CHECK: begin
               if (op_q == OP_CLR) begin
                  acc      <= '0;
                  overflow <= 1'b0;
                  invalid  <= 1'b0;
               end else if (bad_digit) begin
                  invalid  <= 1'b1;
               end else if (op_q == OP_LOAD) begin
                  acc      <= operand_q;
                  overflow <= 1'b0;
                  invalid  <= 1'b0;
               end else begin
                  carry_q  <= (op_q == OP_SUB);
                  idx_q    <= '0;
               end
            end
            ADD: begin
               work_q  <= work_d;
               carry_q <= carry_out;
               idx_q   <= idx_q + 1'b1;
               // acc is only written once the MSD is known, so partial sums never show.
               if (last_digit) begin
                  acc      <= work_d;
                  overflow <= (op_q == OP_SUB) ? ~carry_out : carry_out;
                  invalid  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'b1000000;
         4'd1: seg7 = 7'b1111001;
         4'd2: seg7 = 7'b0100100;
         4'd3: seg7 = 7'b0110000;
         4'd4: seg7 = 7'b0011001;
         4'd5: seg7 = 7'b0010010;
         4'd6: seg7 = 7'b0000010;
         4'd7: seg7 = 7'b1111000;
         4'd8: seg7 = 7'b0000000;
         4'd9: seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Walk from the MSD down so each digit knows whether everything above it is zero.
   always_comb begin
      logic zero_above;
      hex        = '1;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (acc[4*i +: 4] == 4'd0);
         if (BLANK && (i != 0) && zero_above) hex[7*i +: 7] = 7'b1111111;
         else                                 hex[7*i +: 7] = seg7(acc[4*i +: 4]);
      end
   end

endmodule

// File: tb/tb_bcd_accumulator_display.sv
// Directed bench for bcd_accumulator_display (DIGITS=4, BLANK=1): one task per
// scenario, each with its own inline checks against hand-computed values.
module tb_bcd_accumulator_display;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   localparam logic [6:0] S_0 = 7'b1000000;
   localparam logic [6:0] S_2 = 7'b0100100;
   localparam logic [6:0] S_3 = 7'b0110000;
   localparam logic [6:0] S_B = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] operand = 16'h0000;
   logic        busy, done, overflow, invalid;
   logic [15:0] acc;
   logic [27:0] hex;
   logic [1:0]  dbg_state;

   int tests = 0;
   int fails = 0;

   bcd_accumulator_display #(.DIGITS(4), .BLANK(1'b1)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .start    (start),
      .op       (op),
      .operand  (operand),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .invalid  (invalid),
      .acc      (acc),
      .hex      (hex),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Issues one request; edges are numbered from the sampling edge (0).
   // If pulse_at >= 0, a clear request is pulsed after that edge while busy.
   task automatic do_op(input logic [1:0] o, input logic [15:0] v, input int pulse_at,
                        output int done_edge, output int idle_edge, output int ndone);
      int e;
      @(negedge clk);
      op = o; operand = v; start = 1'b1;
      @(posedge clk);
      e = 0; ndone = 0; done_edge = -1; idle_edge = -1;
      @(negedge clk);
      while (e < 20) begin
         if (e == pulse_at) begin
            start = 1'b1; op = OP_CLR; operand = 16'h0000;
         end else begin
            start = 1'b0;
         end
         if (done) begin ndone++; done_edge = e; end
         if (!busy) begin idle_edge = e; break; end
         @(posedge clk); e++;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      tests++; if (acc !== 16'h0000) begin fails++; $display("FAIL reset_acc got %h exp 0000", acc); end
      tests++; if (hex !== {S_B, S_B, S_B, S_0}) begin fails++; $display("FAIL reset_hex got %b exp %b", hex, {S_B, S_B, S_B, S_0}); end
      tests++; if ({busy, done, overflow, invalid} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {busy, done, overflow, invalid}); end
      tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load_add();
      int de, ie, nd;
      do_op(OP_LOAD, 16'h1234, -1, de, ie, nd);
      tests++; if (acc !== 16'h1234) begin fails++; $display("FAIL load_acc got %h exp 1234", acc); end
      tests++; if (de !== 1 || ie !== 2) begin fails++; $display("FAIL load_timing got done@%0d idle@%0d exp 1,2", de, ie); end
      do_op(OP_ADD, 16'h0999, -1, de, ie, nd);
      tests++; if (acc !== 16'h2233 || overflow !== 1'b0) begin fails++; $display("FAIL add_acc got %h ovf %b exp 2233 0", acc, overflow); end
      tests++; if (de !== 5 || ie !== 6 || nd !== 1) begin fails++; $display("FAIL add_timing got done@%0d idle@%0d n=%0d exp 5,6,1", de, ie, nd); end
      tests++; if (hex !== {S_2, S_2, S_3, S_3}) begin fails++; $display("FAIL add_hex got %b exp %b", hex, {S_2, S_2, S_3, S_3}); end
   endtask

   task automatic test_overflow();
      int de, ie, nd;
      do_op(OP_LOAD, 16'h9999, -1, de, ie, nd);
      do_op(OP_ADD, 16'h0001, -1, de, ie, nd);
      tests++; if (acc !== 16'h0000 || overflow !== 1'b1) begin fails++; $display("FAIL wrap_acc got %h ovf %b exp 0000 1", acc, overflow); end
      tests++; if (hex !== {S_B, S_B, S_B, S_0}) begin fails++; $display("FAIL wrap_hex got %b exp %b", hex, {S_B, S_B, S_B, S_0}); end
   endtask

   task automatic test_subtract();
      int de, ie, nd;
      do_op(OP_LOAD, 16'h0005, -1, de, ie, nd);
      do_op(OP_SUB, 16'h0007, -1, de, ie, nd);
      tests++; if (acc !== 16'h9998 || overflow !== 1'b1) begin fails++; $display("FAIL sub_borrow got %h ovf %b exp 9998 1", acc, overflow); end
      do_op(OP_LOAD, 16'h0007, -1, de, ie, nd);
      do_op(OP_SUB, 16'h0005, -1, de, ie, nd);
      tests++; if (acc !== 16'h0002 || overflow !== 1'b0) begin fails++; $display("FAIL sub_plain got %h ovf %b exp 0002 0", acc, overflow); end
      tests++; if (hex !== {S_B, S_B, S_B, S_2}) begin fails++; $display("FAIL sub_hex got %b exp %b", hex, {S_B, S_B, S_B, S_2}); end
   endtask

   task automatic test_invalid();
      int de, ie, nd;
      do_op(OP_ADD, 16'h00A3, -1, de, ie, nd);
      tests++; if (invalid !== 1'b1 || acc !== 16'h0002) begin fails++; $display("FAIL inv_set got inv %b acc %h exp 1 0002", invalid, acc); end
      tests++; if (de !== 1 || ie !== 2) begin fails++; $display("FAIL inv_timing got done@%0d idle@%0d exp 1,2", de, ie); end
      do_op(OP_ADD, 16'h0001, -1, de, ie, nd);
      tests++; if (invalid !== 1'b0 || acc !== 16'h0003) begin fails++; $display("FAIL inv_clear got inv %b acc %h exp 0 0003", invalid, acc); end
      do_op(OP_CLR, 16'h0000, -1, de, ie, nd);
      tests++; if (acc !== 16'h0000 || overflow !== 1'b0 || de !== 1) begin fails++; $display("FAIL clear got acc %h ovf %b done@%0d exp 0000 0 1", acc, overflow, de); end
   endtask

   task automatic test_ignored_start();
      int de, ie, nd;
      do_op(OP_LOAD, 16'h0003, -1, de, ie, nd);
      do_op(OP_ADD, 16'h0010, 3, de, ie, nd);
      tests++; if (acc !== 16'h0013 || nd !== 1 || ie !== 6) begin fails++; $display("FAIL busy_start got acc %h n=%0d idle@%0d exp 0013 1 6", acc, nd, ie); end
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_idle got busy %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      int e;
      int d_first, d_second;
      d_first = -1; d_second = -1;
      @(negedge clk);
      op = OP_ADD; operand = 16'h0001; start = 1'b1;
      @(posedge clk); e = 0;
      @(negedge clk);
      while (e < 14) begin
         if (done) begin
            if (d_first < 0) d_first = e; else d_second = e;
         end
         if (e == 12) start = 1'b0;
         @(posedge clk); e++;
         @(negedge clk);
      end
      start = 1'b0;
      tests++; if (d_first !== 5 || d_second !== 12) begin fails++; $display("FAIL b2b_done got %0d,%0d exp 5,12", d_first, d_second); end
      tests++; if (acc !== 16'h0015 || busy !== 1'b0) begin fails++; $display("FAIL b2b_acc got %h busy %b exp 0015 0", acc, busy); end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      op = OP_ADD; operand = 16'h0111; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++; if (acc !== 16'h0000 || {busy, done, overflow, invalid} !== 4'b0000) begin fails++; $display("FAIL mid_reset got acc %h flags %b exp 0000 0000", acc, {busy, done, overflow, invalid}); end
      tests++; if (hex !== {S_B, S_B, S_B, S_0}) begin fails++; $display("FAIL mid_reset_hex got %b exp %b", hex, {S_B, S_B, S_B, S_0}); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL mid_reset_quiet got %0d active cycles exp 0", seen); end
   endtask

   initial begin
      test_reset();
      test_load_add();
      test_overflow();
      test_subtract();
      test_invalid();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
